// File: rtl/game_pkg.sv
// Shared types and constants for the hook scene sequencer.
//   state_t   : sequencer states (scene init, hook cycle, scene done)
//   PH_*      : hook_phase output codes
//   phase_of  : maps a state to its hook_phase code
package game_pkg;

   typedef enum logic [3:0] {
      ST_BG       = 4'd0,
      ST_GEN_X    = 4'd1,
      ST_GEN_Y    = 4'd2,
      ST_DRAW_OBJ = 4'd3,
      ST_NEXT_OBJ = 4'd4,
      ST_SWING    = 4'd5,
      ST_DROP     = 4'd6,
      ST_DRAG     = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   localparam logic [1:0] PH_INIT  = 2'd0;
   localparam logic [1:0] PH_SWING = 2'd1;
   localparam logic [1:0] PH_DROP  = 2'd2;
   localparam logic [1:0] PH_DRAG  = 2'd3;

   function automatic logic [1:0] phase_of(input state_t s);
      logic [1:0] ph;
      ph = PH_INIT;
      case (s)
         ST_SWING: ph = PH_SWING;
         ST_DROP:  ph = PH_DROP;
         ST_DRAG:  ph = PH_DRAG;
         default:  ph = PH_INIT;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/angle_swing_counter.sv
// Hook angle index counter that bounces between 0 and ANGLE_STEPS-1.
//   clk, resetn : clock, synchronous active-low reset
//   load_start  : return to START_ANGLE, clockwise
//   step_en     : advance one angle step in the current direction
//   angle_idx   : current angle index
//   clockwise   : 1 = index increasing
module angle_swing_counter #(
   parameter int ANGLE_STEPS = 11,
   parameter int ANGLE_W     = 4,
   parameter int START_ANGLE = 5
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load_start,
   input  logic               step_en,
   output logic [ANGLE_W-1:0] angle_idx,
   output logic               clockwise
);

   localparam logic [ANGLE_W-1:0] MAX_IDX   = ANGLE_W'(ANGLE_STEPS - 1);
   localparam logic [ANGLE_W-1:0] START_IDX = ANGLE_W'(START_ANGLE);

   logic               go_up;
   logic [ANGLE_W-1:0] up_idx;
   logic [ANGLE_W-1:0] dn_idx;

   // Direction is re-derived at the ends so the index can never escape the
   // range, even if START_ANGLE sits on a boundary.
   assign go_up  = clockwise ? (angle_idx != MAX_IDX) : (angle_idx == '0);
   assign up_idx = angle_idx + 1'b1;
   assign dn_idx = angle_idx - 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn || load_start) begin
         angle_idx <= START_IDX;
         clockwise <= 1'b1;
      end else if (step_en) begin
         if (go_up) begin
            angle_idx <= up_idx;
            clockwise <= (up_idx != MAX_IDX);
         end else begin
            angle_idx <= dn_idx;
            clockwise <= (dn_idx == '0);
         end
      end
   end

endmodule

// File: rtl/hook_scene_sequencer.sv
// Scene sequencer: background, NUM_GOLD gold and NUM_STONE stone objects
// (each with X/Y randomisation), then the hook swing/drop/drag cycle.
//   clk, resetn            : clock, synchronous active-low reset
//   frame                  : one-cycle animation tick
//   drop, game_end         : player drop request, end-of-game request
//   draw_bg_done           : background drawer finished
//   draw_obj_done          : object drawer finished current object
//   drop_end, drag_end     : hook hit something / hook back at origin
//   enable_draw_background : high while drawing the background
//   enable_random          : high in GEN_X and GEN_Y
//   enable_draw_obj        : high while drawing an object
//   obj_is_stone, obj_index: kind and index of current object
//   angle_idx, clockwise   : hook angle and swing direction
//   hook_phase             : 0 init, 1 swing, 2 drop, 3 drag
//   drop_step, drag_step   : per-frame hook advance pulses
//   resetn_objects         : low for the single DONE cycle
module hook_scene_sequencer #(
   parameter int NUM_GOLD    = 5,
   parameter int NUM_STONE   = 5,
   parameter int CNT_W       = 3,
   parameter int ANGLE_STEPS = 11,
   parameter int ANGLE_W     = 4,
   parameter int START_ANGLE = 5
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame,
   input  logic               drop,
   input  logic               game_end,
   input  logic               draw_bg_done,
   input  logic               draw_obj_done,
   input  logic               drop_end,
   input  logic               drag_end,
   output logic               enable_draw_background,
   output logic               enable_random,
   output logic               enable_draw_obj,
   output logic               obj_is_stone,
   output logic [CNT_W-1:0]   obj_index,
   output logic [ANGLE_W-1:0] angle_idx,
   output logic               clockwise,
   output logic [1:0]         hook_phase,
   output logic               drop_step,
   output logic               drag_step,
   output logic               resetn_objects
);

   import game_pkg::*;

   localparam int TOTAL = NUM_GOLD + NUM_STONE;

   state_t state;
   state_t nxt;
   logic   en_bg_q;
   logic   last_gold;
   logic   last_stone;
   logic   swing_step;

   assign last_gold  = (int'(obj_index) >= NUM_GOLD - 1);
   assign last_stone = (int'(obj_index) >= NUM_STONE - 1);

   always_comb begin
      nxt = ST_BG;
      case (state)
         ST_BG:       nxt = !draw_bg_done ? ST_BG :
                            (TOTAL == 0) ? ST_SWING : ST_GEN_X;
         ST_GEN_X:    nxt = ST_GEN_Y;
         ST_GEN_Y:    nxt = ST_DRAW_OBJ;
         ST_DRAW_OBJ: nxt = draw_obj_done ? ST_NEXT_OBJ : ST_DRAW_OBJ;
         ST_NEXT_OBJ: begin
            if (!obj_is_stone)
               nxt = (!last_gold || NUM_STONE != 0) ? ST_GEN_X : ST_SWING;
            else
               nxt = !last_stone ? ST_GEN_X : ST_SWING;
         end
         ST_SWING:    nxt = game_end ? ST_DONE : drop     ? ST_DROP  : ST_SWING;
         ST_DROP:     nxt = game_end ? ST_DONE : drop_end ? ST_DRAG  : ST_DROP;
         ST_DRAG:     nxt = game_end ? ST_DONE : drag_end ? ST_SWING : ST_DRAG;
         ST_DONE:     nxt = ST_BG;
         default:     nxt = ST_BG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_BG;
         en_bg_q      <= 1'b0;
         obj_index    <= '0;
         obj_is_stone <= (NUM_GOLD == 0);
      end else begin
         state <= nxt;
         // Registered from the next state so the background enable stays low
         // in the cycle following reset.
         en_bg_q <= (nxt == ST_BG);
         case (state)
            ST_NEXT_OBJ: begin
               if (!obj_is_stone) begin
                  if (!last_gold) begin
                     obj_index <= obj_index + 1'b1;
                  end else if (NUM_STONE != 0) begin
                     obj_is_stone <= 1'b1;
                     obj_index    <= '0;
                  end
               end else if (!last_stone) begin
                  obj_index <= obj_index + 1'b1;
               end
            end
            ST_DONE: begin
               obj_index    <= '0;
               obj_is_stone <= (NUM_GOLD == 0);
            end
            default: ;
         endcase
      end
   end

   // A frame coinciding with drop/game_end leaves the angle frozen.
   assign swing_step = frame & (state == ST_SWING) & ~drop & ~game_end;

   angle_swing_counter #(
      .ANGLE_STEPS(ANGLE_STEPS),
      .ANGLE_W    (ANGLE_W),
      .START_ANGLE(START_ANGLE)
   ) u_angle (
      .clk       (clk),
      .resetn    (resetn),
      .load_start(state == ST_DONE),
      .step_en   (swing_step),
      .angle_idx (angle_idx),
      .clockwise (clockwise)
   );

   assign enable_draw_background = en_bg_q;
   assign enable_random          = (state == ST_GEN_X) || (state == ST_GEN_Y);
   assign enable_draw_obj        = (state == ST_DRAW_OBJ);
   assign hook_phase             = phase_of(state);
   assign resetn_objects         = (state != ST_DONE);
   // Leaving DROP/DRAG suppresses the step pulse of that frame.
   assign drop_step = resetn & frame & (state == ST_DROP) & ~drop_end & ~game_end;
   assign drag_step = resetn & frame & (state == ST_DRAG) & ~drag_end & ~game_end;

endmodule

// File: tb/tb_hook_scene_sequencer.sv
// Self-checking bench for hook_scene_sequencer: default configuration plus
// NUM_GOLD=0/NUM_STONE=2 and NUM_GOLD=0/NUM_STONE=0 instances.
module tb_hook_scene_sequencer;

   localparam int STEPS = 11;
   localparam int START = 5;
   localparam int MAXA  = STEPS - 1;
   localparam int PER   = 2 * MAXA;
   localparam logic [1:0] PH_SW = 2'd1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rn [3];
   logic bg_done [3];
   logic obj_done [3];
   logic frame, drop, game_end, drop_end, drag_end;

   logic       en_bg [3];
   logic       en_rand [3];
   logic       en_obj [3];
   logic       stone [3];
   logic [2:0] oidx [3];
   logic [3:0] ang [3];
   logic       cw [3];
   logic [1:0] ph [3];
   logic       d_step [3];
   logic       g_step [3];
   logic       rno [3];

   int checks = 0;
   int errors = 0;
   int n = 0;   // frames taken in SWING since the last scene start

   hook_scene_sequencer #(.NUM_GOLD(5), .NUM_STONE(5), .CNT_W(3),
      .ANGLE_STEPS(11), .ANGLE_W(4), .START_ANGLE(5)) u0 (
      .clk(clk), .resetn(rn[0]), .frame(frame), .drop(drop), .game_end(game_end),
      .draw_bg_done(bg_done[0]), .draw_obj_done(obj_done[0]),
      .drop_end(drop_end), .drag_end(drag_end),
      .enable_draw_background(en_bg[0]), .enable_random(en_rand[0]),
      .enable_draw_obj(en_obj[0]), .obj_is_stone(stone[0]), .obj_index(oidx[0]),
      .angle_idx(ang[0]), .clockwise(cw[0]), .hook_phase(ph[0]),
      .drop_step(d_step[0]), .drag_step(g_step[0]), .resetn_objects(rno[0]));

   hook_scene_sequencer #(.NUM_GOLD(0), .NUM_STONE(2), .CNT_W(3),
      .ANGLE_STEPS(11), .ANGLE_W(4), .START_ANGLE(5)) u1 (
      .clk(clk), .resetn(rn[1]), .frame(frame), .drop(drop), .game_end(game_end),
      .draw_bg_done(bg_done[1]), .draw_obj_done(obj_done[1]),
      .drop_end(drop_end), .drag_end(drag_end),
      .enable_draw_background(en_bg[1]), .enable_random(en_rand[1]),
      .enable_draw_obj(en_obj[1]), .obj_is_stone(stone[1]), .obj_index(oidx[1]),
      .angle_idx(ang[1]), .clockwise(cw[1]), .hook_phase(ph[1]),
      .drop_step(d_step[1]), .drag_step(g_step[1]), .resetn_objects(rno[1]));

   hook_scene_sequencer #(.NUM_GOLD(0), .NUM_STONE(0), .CNT_W(3),
      .ANGLE_STEPS(11), .ANGLE_W(4), .START_ANGLE(5)) u2 (
      .clk(clk), .resetn(rn[2]), .frame(frame), .drop(drop), .game_end(game_end),
      .draw_bg_done(bg_done[2]), .draw_obj_done(obj_done[2]),
      .drop_end(drop_end), .drag_end(drag_end),
      .enable_draw_background(en_bg[2]), .enable_random(en_rand[2]),
      .enable_draw_obj(en_obj[2]), .obj_is_stone(stone[2]), .obj_index(oidx[2]),
      .angle_idx(ang[2]), .clockwise(cw[2]), .hook_phase(ph[2]),
      .drop_step(d_step[2]), .drag_step(g_step[2]), .resetn_objects(rno[2]));

   // Reference swing: the hook angle is a triangle wave of period 2*(STEPS-1)
   // whose phase starts at START and advances once per accepted frame.
   function automatic int tri_pos(input int k);
      return (START + k) % PER;
   endfunction
   function automatic int tri_angle(input int k);
      int p;
      p = tri_pos(k);
      return (p <= MAXA) ? p : PER - p;
   endfunction
   function automatic int tri_cw(input int k);
      return (tri_pos(k) < MAXA) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset(input int w, input int exp_stone);
      chk("rst_phase",  32'(ph[w]), 0);
      chk("rst_index",  32'(oidx[w]), 0);
      chk("rst_stone",  32'(stone[w]), exp_stone);
      chk("rst_angle",  32'(ang[w]), START);
      chk("rst_cw",     32'(cw[w]), 1);
      chk("rst_en_bg",  32'(en_bg[w]), 0);
      chk("rst_en_rnd", 32'(en_rand[w]), 0);
      chk("rst_en_obj", 32'(en_obj[w]), 0);
      chk("rst_rno",    32'(rno[w]), 1);
   endtask

   // Drives the drawers of DUT w through scene init. Expected object order is
   // a queue: all gold indices, then all stone indices.
   task automatic run_init(input int w, input int bg_lat, input int obj_lat,
                           input bit noise, input int stop_idx);
      int ng, ns, n_rand, n_obj, bgc, objc;
      bit fin, stopped;
      logic [3:0] e;
      logic [3:0] exp_q[$];
      ng = (w == 0) ? 5 : 0;
      ns = (w == 0) ? 5 : (w == 1) ? 2 : 0;
      for (int g = 0; g < ng; g++) exp_q.push_back({1'b0, 3'(g)});
      for (int s = 0; s < ns; s++) exp_q.push_back({1'b1, 3'(s)});
      n_rand = 0; n_obj = 0; bgc = 0; objc = 0; fin = 0; stopped = 0;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         bg_done[w] = 1'b0;
         obj_done[w] = 1'b0;
         if (ph[w] == PH_SW) begin
            fin = 1;
         end else begin
            if (en_rand[w]) n_rand++;
            if (en_bg[w]) begin
               bgc++;
               if (bgc >= bg_lat) bg_done[w] = 1'b1;
            end else bgc = 0;
            if (en_obj[w]) begin
               if (objc == 0) begin
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
                  chk("obj_kind",  32'(stone[w]), 32'(e[3]));
                  chk("obj_index", 32'(oidx[w]), 32'(e[2:0]));
                  n_obj++;
                  if (stop_idx >= 0 && int'(oidx[w]) == stop_idx && !stone[w]) begin
                     stopped = 1;
                     fin = 1;
                  end
               end
               objc++;
               if (!fin && objc >= obj_lat) obj_done[w] = 1'b1;
            end else objc = 0;
            if (!fin) begin
               if (noise) begin
                  frame    = 1'($urandom_range(0, 1));
                  drop     = 1'($urandom_range(0, 1));
                  game_end = 1'($urandom_range(0, 1));
               end
               step();
            end
         end
      end
      frame = 0; drop = 0; game_end = 0;
      bg_done[w] = 1'b0;
      obj_done[w] = 1'b0;
      if (stop_idx < 0) begin
         chk("init_reaches_swing", 32'(fin), 1);
         chk("rand_pulses", n_rand, 2 * (ng + ns));
         chk("obj_count", n_obj, ng + ns);
      end else begin
         chk("reached_stop_obj", 32'(stopped), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit f;
      for (int i = 0; i < 3; i++) begin
         rn[i] = 0; bg_done[i] = 0; obj_done[i] = 0;
      end
      frame = 0; drop = 0; game_end = 0; drop_end = 0; drag_end = 0;
      step(); step();
      rn[0] = 1;
      check_reset(0, 0);

      // First scene, fixed drawer latencies
      run_init(0, 3, 2, 0, -1);
      chk("init_angle", 32'(ang[0]), START);
      chk("init_cw", 32'(cw[0]), 1);

      // 12 consecutive frames of swing
      n = 0;
      for (int k = 0; k < 12; k++) begin
         frame = 1; step(); n++;
         chk("swing_angle", 32'(ang[0]), tri_angle(n));
         chk("swing_cw", 32'(cw[0]), tri_cw(n));
      end
      frame = 0;
      chk("swing12_angle", 32'(ang[0]), 3);
      chk("swing12_cw", 32'(cw[0]), 0);

      // Random frame pattern during swing
      for (int k = 0; k < 40; k++) begin
         f = 1'($urandom_range(0, 1));
         frame = f; step();
         if (f) n++;
         chk("rswing_angle", 32'(ang[0]), tri_angle(n));
         chk("rswing_cw", 32'(cw[0]), tri_cw(n));
         chk("rswing_phase", 32'(ph[0]), 1);
      end
      frame = 0;

      // Swing to angle 7
      for (int k = 0; k < 25 && tri_angle(n) != 7; k++) begin
         frame = 1; step(); n++;
         chk("to7_angle", 32'(ang[0]), tri_angle(n));
      end
      frame = 0;
      chk("at7", 32'(ang[0]), 7);

      // Drop with a coincident frame: angle frozen
      drop = 1; frame = 1; step(); drop = 0; frame = 0;
      chk("drop_phase", 32'(ph[0]), 2);
      chk("drop_angle", 32'(ang[0]), 7);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         frame = (k % 2 == 0); #1;
         if (d_step[0]) cnt++;
         chk("drop_step_gate", 32'(d_step[0]), 32'(frame));
         step();
      end
      frame = 0;
      chk("drop_pulses", cnt, 4);
      chk("drop_angle_hold", 32'(ang[0]), 7);
      drop_end = 1; frame = 1; #1;
      chk("drop_end_no_step", 32'(d_step[0]), 0);
      step(); drop_end = 0; frame = 0;
      chk("drag_phase", 32'(ph[0]), 3);
      frame = 1; #1;
      chk("drag_step_on", 32'(g_step[0]), 1);
      step(); frame = 0; #1;
      chk("drag_step_off", 32'(g_step[0]), 0);
      drag_end = 1; step(); drag_end = 0;
      chk("back_swing_phase", 32'(ph[0]), 1);
      chk("back_swing_angle", 32'(ang[0]), 7);
      chk("back_swing_cw", 32'(cw[0]), tri_cw(n));

      // game_end beats drag_end in DRAG
      drop = 1; step(); drop = 0;
      chk("drop2_phase", 32'(ph[0]), 2);
      drop_end = 1; step(); drop_end = 0;
      chk("drag2_phase", 32'(ph[0]), 3);
      game_end = 1; drag_end = 1; #1;
      chk("pre_done_rno", 32'(rno[0]), 1);
      step(); game_end = 0; drag_end = 0;
      chk("done_phase", 32'(ph[0]), 0);
      chk("done_rno", 32'(rno[0]), 0);
      step();
      chk("new_scene_rno", 32'(rno[0]), 1);
      chk("new_scene_angle", 32'(ang[0]), START);
      chk("new_scene_cw", 32'(cw[0]), 1);
      chk("new_scene_en_bg", 32'(en_bg[0]), 1);
      chk("new_scene_index", 32'(oidx[0]), 0);
      chk("new_scene_stone", 32'(stone[0]), 0);

      // Second scene: random latencies and ignored frame/drop/game_end noise
      n = 0;
      run_init(0, $urandom_range(1, 4), $urandom_range(1, 4), 1, -1);
      chk("noise_angle", 32'(ang[0]), START);
      chk("noise_cw", 32'(cw[0]), 1);

      // Reset in the middle of DRAW_OBJ for gold index 3
      game_end = 1; step(); game_end = 0;
      chk("done2_rno", 32'(rno[0]), 0);
      step();
      run_init(0, 2, 3, 0, 3);
      chk("stop_en_obj", 32'(en_obj[0]), 1);
      chk("stop_index", 32'(oidx[0]), 3);
      rn[0] = 0; step(); rn[0] = 1;
      check_reset(0, 0);

      // NUM_GOLD=0, NUM_STONE=2
      rn[1] = 1;
      check_reset(1, 1);
      run_init(1, 1, 2, 0, -1);

      // NUM_GOLD=0, NUM_STONE=0: straight from BG to SWING
      rn[2] = 1;
      check_reset(2, 1);
      run_init(2, 2, 1, 0, -1);
      chk("empty_angle", 32'(ang[2]), START);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
